// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - ALU issue sequencer: decodes a MIPS instruction, drives a registered ALU, returns result.
// Optional overflow flag output rsp_ovf is built when ALU_SEQ_OVF_EN is defined.
module alu_issue_seq #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_taken,
  output logic        rsp_illegal
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic        rsp_ovf
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;
  typedef enum logic [2:0] {K_NONE, K_ADD, K_SUB, K_BEQ, K_BNE} kind_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY - 1);

  state_t      state_q;
  kind_t       kind_q;
  logic [2:0]  cnt_q;
  logic        req_ready_q;
  logic [31:0] alu_in1_q;
  logic [31:0] alu_in2_q;
  logic [2:0]  alu_op_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_zero_q;
  logic        rsp_taken_q;
  logic        rsp_illegal_q;
  logic        rsp_ovf_q;
  logic        ovf_now;

  logic        dec_legal;
  logic [2:0]  dec_op;
  logic [31:0] dec_in1;
  logic [31:0] dec_in2;
  kind_t       dec_kind;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = OP_ADD;
    dec_in1   = rs_val;
    dec_in2   = rt_val;
    dec_kind  = K_NONE;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_op = OP_ADD; dec_kind = K_ADD; end
          6'h22: begin dec_op = OP_SUB; dec_kind = K_SUB; end
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h2A: dec_op = OP_SLT;
          6'h00, 6'h02: begin
            dec_op  = (funct == 6'h00) ? OP_SLL : OP_SRL;
            dec_in1 = rt_val;
            dec_in2 = {27'b0, shamt};
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h23, 6'h2B: begin dec_op = OP_ADD; dec_in2 = imm_sext; dec_kind = K_ADD; end
      6'h0A: begin dec_op = OP_SLT; dec_in2 = imm_sext; end
      6'h0C: begin dec_op = OP_AND; dec_in2 = imm_zext; end
      6'h0D: begin dec_op = OP_OR;  dec_in2 = imm_zext; end
      6'h04: begin dec_op = OP_SUB; dec_kind = K_BEQ; end
      6'h05: begin dec_op = OP_SUB; dec_kind = K_BNE; end
      default: dec_legal = 1'b0;
    endcase
  end

  // Signed overflow judged on the held operands against the returned result.
  always_comb begin
    ovf_now = 1'b0;
    if (kind_q == K_ADD)
      ovf_now = (alu_in1_q[31] == alu_in2_q[31]) && (alu_out[31] != alu_in1_q[31]);
    else if (kind_q == K_SUB)
      ovf_now = (alu_in1_q[31] != alu_in2_q[31]) && (alu_out[31] != alu_in1_q[31]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      kind_q        <= K_NONE;
      cnt_q         <= 3'd0;
      req_ready_q   <= 1'b0;
      alu_in1_q     <= 32'd0;
      alu_in2_q     <= 32'd0;
      alu_op_q      <= 3'd0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            if (dec_legal) begin
              alu_in1_q <= dec_in1;
              alu_in2_q <= dec_in2;
              alu_op_q  <= dec_op;
              kind_q    <= dec_kind;
              state_q   <= S_EXEC;
            end else begin
              rsp_data_q    <= 32'd0;
              rsp_zero_q    <= 1'b0;
              rsp_taken_q   <= 1'b0;
              rsp_ovf_q     <= 1'b0;
              rsp_illegal_q <= 1'b1;
              rsp_valid_q   <= 1'b1;
              state_q       <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          cnt_q   <= CNT_INIT;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            rsp_data_q  <= alu_out;
            rsp_zero_q  <= alu_zero;
            rsp_taken_q <= (kind_q == K_BEQ) ? alu_zero :
                           (kind_q == K_BNE) ? ~alu_zero : 1'b0;
            rsp_ovf_q   <= ovf_now;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign alu_op      = alu_op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_taken   = rsp_taken_q;
  assign rsp_illegal = rsp_illegal_q;
`ifdef ALU_SEQ_OVF_EN
  assign rsp_ovf     = rsp_ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = rsp_ovf_q ^ ovf_now;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - randomized bench for alu_issue_seq against an instruction-level model.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [15:0] imm = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [2:0]  alu_op;
  logic [31:0] alu_out = '0;
  logic        alu_zero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_taken;
  logic        rsp_illegal;
`ifdef ALU_SEQ_OVF_EN
  logic        rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_in1 = '0;
  logic [31:0] exp_in2 = '0;
  logic [2:0]  exp_op = '0;

  alu_issue_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .imm(imm),
    .rs_val(rs_val), .rt_val(rt_val),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
`ifdef ALU_SEQ_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Registered single-cycle ALU standing in for the real one.
  always @(posedge clk) begin
    case (alu_op)
      3'd0: alu_out <= alu_in1 + alu_in2;
      3'd1: alu_out <= alu_in1 - alu_in2;
      3'd2: alu_out <= alu_in1 & alu_in2;
      3'd3: alu_out <= alu_in1 | alu_in2;
      3'd4: alu_out <= alu_in1 << alu_in2[4:0];
      3'd5: alu_out <= alu_in1 >> alu_in2[4:0];
      3'd6: alu_out <= (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      default: alu_out <= 32'd0;
    endcase
    alu_zero <= (alu_in1 == alu_in2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                                output bit legal, output logic [2:0] op, output logic [31:0] in1,
                                output logic [31:0] in2, output logic [31:0] res, output bit zero,
                                output bit taken, output bit ovf);
    logic [31:0] sx;
    longint s;
    bit add_cls;
    bit sub_cls;
    sx = {{16{im[15]}}, im};
    legal = 1; op = 0; in1 = rs; in2 = rt; res = 0; taken = 0;
    add_cls = 0; sub_cls = 0;
    case (opc)
      6'h00: case (fn)
        6'h20: begin op = 0; res = rs + rt; add_cls = 1; end
        6'h22: begin op = 1; res = rs - rt; sub_cls = 1; end
        6'h24: begin op = 2; res = rs & rt; end
        6'h25: begin op = 3; res = rs | rt; end
        6'h2A: begin op = 6; res = (rs < rt) ? 1 : 0; end
        6'h00: begin op = 4; in1 = rt; in2 = 32'(sh); res = rt << sh; end
        6'h02: begin op = 5; in1 = rt; in2 = 32'(sh); res = rt >> sh; end
        default: legal = 0;
      endcase
      6'h08, 6'h23, 6'h2B: begin op = 0; in2 = sx; res = rs + sx; add_cls = 1; end
      6'h0A: begin op = 6; in2 = sx; res = (rs < sx) ? 1 : 0; end
      6'h0C: begin op = 2; in2 = 32'(im); res = rs & 32'(im); end
      6'h0D: begin op = 3; in2 = 32'(im); res = rs | 32'(im); end
      6'h04: begin op = 1; res = rs - rt; taken = (rs == rt); end
      6'h05: begin op = 1; res = rs - rt; taken = (rs != rt); end
      default: legal = 0;
    endcase
    zero = (in1 == in2);
    s = add_cls ? longint'($signed(in1)) + longint'($signed(in2))
                : longint'($signed(in1)) - longint'($signed(in2));
    ovf = (add_cls || sub_cls) && (s > 64'sd2147483647 || s < -64'sd2147483648);
  endfunction

  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                           input int stall);
    bit legal, zero, taken, ovf;
    logic [2:0] op;
    logic [31:0] in1, in2, res, exp_data;
    int cyc;
    model(opc, fn, sh, im, rs, rt, legal, op, in1, in2, res, zero, taken, ovf);
    exp_data = legal ? res : 32'd0;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    opcode = opc; funct = fn; shamt = sh; imm = im; rs_val = rs; rt_val = rt;
    rsp_ready = (stall == 0);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (legal) begin exp_op = op; exp_in1 = in1; exp_in2 = in2; end
    check("req_ready_busy", 32'(req_ready), 32'd0);
    check("alu_op", 32'(alu_op), 32'(exp_op));
    check("alu_in1", alu_in1, exp_in1);
    check("alu_in2", alu_in2, exp_in2);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check("rsp_latency", 32'(cyc), legal ? 32'd3 : 32'd1);
    check("rsp_illegal", 32'(rsp_illegal), 32'(!legal));
    check("rsp_data", rsp_data, exp_data);
    check("rsp_taken", 32'(rsp_taken), 32'(legal && taken));
    if (legal) check("rsp_zero", 32'(rsp_zero), 32'(zero));
`ifdef ALU_SEQ_OVF_EN
    check("rsp_ovf", 32'(rsp_ovf), 32'(legal && ovf));
`endif
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, exp_data);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rsp_done", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
    check("alu_in1_kept", alu_in1, exp_in1);
    check("alu_op_kept", 32'(alu_op), 32'(exp_op));
  endtask

  logic [5:0] opc_tab [12] = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h0A,
                               6'h0C, 6'h0D, 6'h04, 6'h05, 6'h3F, 6'h11};
  logic [5:0] fn_tab [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h21, 6'h3F};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_in1", alu_in1, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    run_instr(6'h00, 6'h20, 5'd0, 16'h0000, 32'd10, 32'd5, 0);
    run_instr(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd3, 32'd0, 0);
    run_instr(6'h0D, 6'h00, 5'd0, 16'h8001, 32'd0, 32'd0, 0);
    run_instr(6'h04, 6'h00, 5'd0, 16'h0000, 32'd7, 32'd7, 0);
    run_instr(6'h05, 6'h00, 5'd0, 16'h0000, 32'd7, 32'd7, 0);
    run_instr(6'h04, 6'h00, 5'd0, 16'h0000, 32'd7, 32'd8, 0);
    run_instr(6'h00, 6'h00, 5'd4, 16'h0000, 32'd99, 32'd1, 0);
    run_instr(6'h3F, 6'h00, 5'd0, 16'h0000, 32'd1, 32'd2, 0);
    run_instr(6'h00, 6'h20, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'd1, 5);

    // Abandon a transaction from the WAIT state.
    opcode = 6'h00; funct = 6'h20; rs_val = 32'd1; rt_val = 32'd2;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_in1", alu_in1, 32'd0);
    check("mid_rst_in2", alu_in2, 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    exp_in1 = '0; exp_in2 = '0; exp_op = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("post_rst_ready", 32'(req_ready), 32'd1);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] rs, rt;
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      run_instr(opc_tab[$urandom_range(0, 11)], fn_tab[$urandom_range(0, 8)],
                5'($urandom), 16'($urandom), rs, rt, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Initiator side of the ALU interface.
- Accepts one decoded MIPS instruction and its operands over a valid/ready request channel, then maps opcode/funct to the 3-bit ALU op code.
- Drives the ALU operand/op inputs, waits out the ALU's registered latency, captures result and zero flag, and returns them on a valid/ready response channel.
- Sits between the decode/register-read stage and writeback/branch logic.

Parameters:
- ALU_LATENCY, 1: clock edges between stable ALU inputs and valid ALU output (registered ALU = 1); legal range 1..7.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- opcode  in  6  instruction [31:26]
- funct  in  6  instruction [5:0]
- shamt  in  5  instruction [10:6]
- imm  in  16  instruction [15:0]
- rs_val  in  32  rs register value
- rt_val  in  32  rt register value
- alu_in1  out  32  ALU operand 1
- alu_in2  out  32  ALU operand 2
- alu_op  out  3  ALU op (0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt)
- alu_out  in  32  ALU result
- alu_zero  in  1  ALU zero flag (in1==in2)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  32  captured result
- rsp_zero  out  1  captured zero flag
- rsp_taken  out  1  branch taken (beq/bne only)
- rsp_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (async, active-high): state IDLE; req_ready=0 while reset asserted, 1 after release; all other outputs 0, including alu_in1/alu_in2/alu_op. Reset mid-operation abandons the transaction; no response is issued.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: decode and register alu_in1/alu_in2/alu_op.
  - Legal instruction: go to EXEC. Illegal: rsp_data=0, rsp_illegal=1, go to RESP, ALU outputs unchanged.
- EXEC: ALU inputs held stable; latency counter loaded with ALU_LATENCY-1; go to WAIT.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: capture alu_out into rsp_data and alu_zero into rsp_zero, compute rsp_taken, go to RESP.
- RESP:
  - rsp_valid=1; response outputs held stable.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - req_ready=0 in all non-IDLE states.
- Latency with ALU_LATENCY=1: accept edge -> rsp_valid high 3 cycles later. Illegal: 1 cycle. Throughput: at most one instruction per 4 cycles.
- ALU inputs stay at their last values after the transaction; they are not cleared.
- Decode, opcode 0 (R-type), by funct:
  - 0x20 add -> op0, in1=rs, in2=rt
  - 0x22 sub -> op1
  - 0x24 and -> op2
  - 0x25 or -> op3
  - 0x2A slt -> op6
  - 0x00 sll -> op4, in1=rt, in2={27'b0,shamt}
  - 0x02 srl -> op5, same operand mapping as sll
  - any other funct -> illegal
- Decode, I-type:
  - 0x08 addi, 0x23 lw, 0x2B sw -> op0, in1=rs, in2=sign-extended imm
  - 0x0A slti -> op6, sign-extended imm
  - 0x0C andi -> op2, zero-extended imm
  - 0x0D ori -> op3, zero-extended imm
  - 0x04 beq / 0x05 bne -> op1, in1=rs, in2=rt
  - any other opcode -> illegal
- slt/slti result is whatever the ALU returns (unsigned 32-bit compare); no correction is applied here.
- rsp_taken: beq = alu_zero, bne = ~alu_zero, 0 for all other instructions. rsp_zero is always the captured flag.
- rsp_illegal is 0 for legal instructions and is cleared on the next accept.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- When defined:
  - Adds output port rsp_ovf (1 bit, reset 0), captured with rsp_data.
  - add/addi/lw/sw: rsp_ovf=1 when in1[31]==in2[31] and alu_out[31]!=in1[31].
  - sub: rsp_ovf=1 when in1[31]!=in2[31] and alu_out[31]!=in1[31].
  - Other ops: rsp_ovf=0.
  - Result is still returned; overflow is flagged only.
- When undefined: the port and logic do not exist.

Test Plan:
- Reset then add: opcode 0, funct 0x20, rs=10, rt=5, rsp_ready=1 -> alu_op=0, alu_in1=10, alu_in2=5; rsp_valid 3 cycles after accept, rsp_data=15, rsp_zero=0, rsp_illegal=0.
- addi with negative imm: opcode 0x08, rs=3, imm=0xFFFF -> alu_in2=0xFFFFFFFF, rsp_data=2. ori: opcode 0x0D, rs=0, imm=0x8001 -> alu_in2=0x00008001, rsp_data=0x8001.
- Branches: beq rs=7, rt=7 -> rsp_zero=1, rsp_taken=1. bne with same operands -> rsp_taken=0. beq rs=7, rt=8 -> rsp_taken=0.
- Shift and illegal: sll rt=1, shamt=4 -> rsp_data=16. opcode 0x3F -> rsp_valid after 1 cycle, rsp_illegal=1, rsp_data=0, alu_op unchanged.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE next cycle, then the next request is accepted.
- Reset during WAIT -> rsp_valid stays 0, all outputs 0, req_ready=1 after release; with ALU_SEQ_OVF_EN, add 0x7FFFFFFF+1 -> rsp_ovf=1, rsp_data=0x80000000.
